// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package FetchStatePackage;

    // Fetch controller states.
    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_WAIT,
        FETCH_HOLD
    } FetchStates;

    // Word presented to the decoder whenever no live instruction is available.
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues single outstanding word reads to
// instruction memory and presents fetched instructions to the decoder.
module instruction_fetch
    import FetchStatePackage::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD     = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirectValid,
    input  logic [31:0] redirectAddress,
    output logic        imemRead,
    output logic [31:0] imemAddress,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic        instructionValid,
    output logic [31:0] instructionData,
    output logic [31:0] pcAddress,
    output logic [31:0] nextPCAddress
);

    FetchStates  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        squash_q, squash_d;
    logic        imem_read_q, imem_read_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_data_q, instr_data_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] next_pc_q, next_pc_d;

    logic [31:0] redirect_target;
    logic [31:0] issue_addr;
    logic [31:0] req_plus4;

    assign redirect_target = word_align(redirectAddress);
    // A redirect seen while issuing wins over the stored fetch PC.
    assign issue_addr      = redirectValid ? redirect_target : fetch_pc_q;
    // Wraps modulo 2^32.
    assign req_plus4       = imem_addr_q + 32'd4;

    // Next-state and next-output decode for the fetch controller.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        squash_d      = squash_q;
        imem_read_d   = imem_read_q;
        imem_addr_d   = imem_addr_q;
        instr_valid_d = 1'b0;
        instr_data_d  = NOP_WORD;
        pc_d          = pc_q;
        next_pc_d     = next_pc_q;

        case (state_q)
            FETCH_IDLE: begin
                state_d     = FETCH_WAIT;
                imem_read_d = 1'b1;
                imem_addr_d = issue_addr;
                fetch_pc_d  = issue_addr;
            end

            FETCH_WAIT: begin
                if (!imem_read_q) begin
                    // Idle-address cycle between requests: issue the next one.
                    imem_read_d = 1'b1;
                    imem_addr_d = issue_addr;
                    fetch_pc_d  = issue_addr;
                end else if (!imemReady) begin
                    // Request stays on the bus; remember a redirect for later.
                    if (redirectValid) begin
                        squash_d   = 1'b1;
                        fetch_pc_d = redirect_target;
                    end
                end else if (squash_q || redirectValid) begin
                    // Wrong-path word returned: drop it and refetch from target.
                    squash_d    = 1'b0;
                    imem_read_d = 1'b0;
                    if (redirectValid) begin
                        fetch_pc_d = redirect_target;
                    end
                end else begin
                    instr_valid_d = 1'b1;
                    instr_data_d  = imemData;
                    pc_d          = imem_addr_q;
                    next_pc_d     = req_plus4;
                    fetch_pc_d    = req_plus4;
                    imem_read_d   = 1'b0;
                    if (stall) begin
                        state_d = FETCH_HOLD;
                    end
                end
            end

            FETCH_HOLD: begin
                instr_valid_d = 1'b1;
                instr_data_d  = instr_data_q;
                if (redirectValid) begin
                    // Held instruction is dropped; fetch straight from target.
                    state_d       = FETCH_WAIT;
                    instr_valid_d = 1'b0;
                    instr_data_d  = NOP_WORD;
                    imem_read_d   = 1'b1;
                    imem_addr_d   = redirect_target;
                    fetch_pc_d    = redirect_target;
                end else if (!stall) begin
                    // Consumed this cycle; continue sequentially.
                    state_d       = FETCH_WAIT;
                    instr_valid_d = 1'b0;
                    instr_data_d  = NOP_WORD;
                    imem_read_d   = 1'b1;
                    imem_addr_d   = next_pc_q;
                    fetch_pc_d    = next_pc_q;
                end
            end

            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // Controller state and registered outputs; async reset abandons any request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= FETCH_IDLE;
            fetch_pc_q    <= RESET_VECTOR;
            squash_q      <= 1'b0;
            imem_read_q   <= 1'b0;
            imem_addr_q   <= RESET_VECTOR;
            instr_valid_q <= 1'b0;
            instr_data_q  <= NOP_WORD;
            pc_q          <= 32'h0000_0000;
            next_pc_q     <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            squash_q      <= squash_d;
            imem_read_q   <= imem_read_d;
            imem_addr_q   <= imem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            pc_q          <= pc_d;
            next_pc_q     <= next_pc_d;
        end
    end

    assign imemRead         = imem_read_q;
    assign imemAddress      = imem_addr_q;
    assign instructionValid = instr_valid_q;
    assign instructionData  = instr_data_q;
    assign pcAddress        = pc_q;
    assign nextPCAddress    = next_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized
// stall/redirect/memory-latency traffic checked by a transaction-level model.
module tb_instruction_fetch;

    localparam logic [31:0] RV     = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam int          Budget = 200;
    localparam int          WdLim  = 60;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirectValid;
    logic [31:0] redirectAddress;
    logic        imemRead;
    logic [31:0] imemAddress;
    logic        imemReady;
    logic [31:0] imemData;
    logic        instructionValid;
    logic [31:0] instructionData;
    logic [31:0] pcAddress;
    logic [31:0] nextPCAddress;

    instruction_fetch #(
        .RESET_VECTOR (RV),
        .NOP_WORD     (NOP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .redirectValid    (redirectValid),
        .redirectAddress  (redirectAddress),
        .imemRead         (imemRead),
        .imemAddress      (imemAddress),
        .imemReady        (imemReady),
        .imemData         (imemData),
        .instructionValid (instructionValid),
        .instructionData  (instructionData),
        .pcAddress        (pcAddress),
        .nextPCAddress    (nextPCAddress)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // Memory responder state
    int   mem_lat   = 1;   // -1: random 0..3 cycles
    int   mem_cnt   = 0;
    logic mem_armed = 1'b0;
    logic mem_force = 1'b0;
    logic spur_en   = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        if (!mem_force) begin
            if (imemRead) begin
                if (!mem_armed) begin
                    mem_armed = 1'b1;
                    mem_cnt   = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
                end
                if (mem_cnt == 0) begin
                    imemReady = 1'b1;
                    imemData  = mem_word(imemAddress);
                    mem_armed = 1'b0;
                end else begin
                    imemReady = 1'b0;
                    imemData  = $urandom;
                    mem_cnt--;
                end
            end else begin
                mem_armed = 1'b0;
                imemReady = spur_en && ($urandom_range(0, 7) == 0);
                imemData  = $urandom;
            end
        end
    endtask

    // Observed transaction logs
    logic [31:0] req_q[$];
    logic [31:0] dlv_pc_q[$];
    logic [31:0] dlv_npc_q[$];

    // Reference model: program-order PC plus request/delivery bookkeeping
    logic [31:0] mon_exp_pc   = RV;
    logic [31:0] mon_req_addr = '0;
    logic [31:0] mon_dlv_addr = '0;
    logic [31:0] mon_prev_data = '0;
    logic [31:0] mon_prev_pc   = '0;
    logic [31:0] mon_prev_npc  = '0;
    logic        mon_in_req    = 1'b0;
    logic        mon_rseen     = 1'b0;
    logic        mon_dlv_pend  = 1'b0;
    logic        mon_dlv_stall = 1'b0;
    logic        mon_hold_pend = 1'b0;
    int          mon_idle      = 0;

    task automatic monitor_cycle();
        logic        dlv_next, hold_next, presented, in_hold, progress, new_stall;
        logic [31:0] cur_pc, tgt, new_addr;
        dlv_next  = 1'b0;
        hold_next = 1'b0;
        presented = 1'b0;
        in_hold   = 1'b0;
        progress  = 1'b0;
        new_stall = 1'b0;
        cur_pc    = '0;
        new_addr  = '0;
        tgt       = {redirectAddress[31:2], 2'b00};

        if (!rst) begin
            mon_exp_pc    = RV;
            mon_in_req    = 1'b0;
            mon_dlv_pend  = 1'b0;
            mon_hold_pend = 1'b0;
            mon_idle      = 0;
            return;
        end

        // Memory request side
        if (mon_in_req) begin
            check_eq("req_held_until_ready", 32'(imemRead), 32'd1);
            if (!imemRead) mon_in_req = 1'b0;
        end
        if (imemRead) begin
            check_eq("req_addr_aligned", 32'(imemAddress[1:0]), 32'd0);
            if (!mon_in_req) begin
                check_eq("req_addr_program_order", imemAddress, mon_exp_pc);
                mon_in_req   = 1'b1;
                mon_req_addr = imemAddress;
                mon_rseen    = 1'b0;
                req_q.push_back(imemAddress);
                progress     = 1'b1;
            end else begin
                check_eq("req_addr_stable", imemAddress, mon_req_addr);
            end
            if (redirectValid) mon_rseen = 1'b1;
            if (imemReady) begin
                mon_in_req = 1'b0;
                dlv_next   = !mon_rseen;
                new_addr   = mon_req_addr;
                new_stall  = stall;
            end
        end

        // Decoder side
        if (mon_dlv_pend) begin
            check_eq("dlv_valid", 32'(instructionValid), 32'd1);
            check_eq("dlv_pc", pcAddress, mon_dlv_addr);
            check_eq("dlv_next_pc", nextPCAddress, mon_dlv_addr + 32'd4);
            check_eq("dlv_data", instructionData, mem_word(mon_dlv_addr));
            dlv_pc_q.push_back(pcAddress);
            dlv_npc_q.push_back(nextPCAddress);
            presented = 1'b1;
            in_hold   = mon_dlv_stall;
            cur_pc    = mon_dlv_addr;
        end else if (mon_hold_pend) begin
            check_eq("hold_valid", 32'(instructionValid), 32'd1);
            check_eq("hold_data", instructionData, mon_prev_data);
            check_eq("hold_pc", pcAddress, mon_prev_pc);
            check_eq("hold_next_pc", nextPCAddress, mon_prev_npc);
            presented = 1'b1;
            in_hold   = 1'b1;
            cur_pc    = mon_prev_pc;
        end else begin
            check_eq("idle_valid", 32'(instructionValid), 32'd0);
            check_eq("idle_data_nop", instructionData, NOP);
        end

        if (presented) begin
            progress  = 1'b1;
            hold_next = in_hold && stall && !redirectValid;
            if (!hold_next) mon_exp_pc = cur_pc + 32'd4;
        end
        if (redirectValid) mon_exp_pc = tgt;

        mon_dlv_pend  = dlv_next;
        mon_dlv_addr  = new_addr;
        mon_dlv_stall = new_stall;
        mon_hold_pend = hold_next;
        mon_prev_data = instructionData;
        mon_prev_pc   = pcAddress;
        mon_prev_npc  = nextPCAddress;

        if (progress) mon_idle = 0;
        else mon_idle++;
        if (mon_idle == WdLim) check_eq("watchdog_idle_cycles", 32'(mon_idle), 32'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_cycle();
        end
    end

    task automatic wait_req(input int n, input string tag);
        int cyc;
        cyc = 0;
        while (req_q.size() < n && cyc < Budget) begin
            step();
            cyc++;
        end
        check_eq(tag, 32'(req_q.size() >= n), 32'd1);
    endtask

    task automatic wait_dlv(input int n, input string tag);
        int cyc;
        cyc = 0;
        while (dlv_pc_q.size() < n && cyc < Budget) begin
            step();
            cyc++;
        end
        check_eq(tag, 32'(dlv_pc_q.size() >= n), 32'd1);
    endtask

    task automatic chk_req(input int idx, input logic [31:0] exp, input string tag);
        if (idx < req_q.size()) check_eq(tag, req_q[idx], exp);
        else check_eq(tag, 32'(req_q.size()), 32'(idx + 1));
    endtask

    task automatic chk_dlv(input int idx, input logic [31:0] pc, input logic [31:0] npc,
                           input string tag);
        if (idx < dlv_pc_q.size()) begin
            check_eq(tag, dlv_pc_q[idx], pc);
            check_eq(tag, dlv_npc_q[idx], npc);
        end else begin
            check_eq(tag, 32'(dlv_pc_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int nreq, ndel, cyc;
        rst             = 1'b0;
        stall           = 1'b0;
        redirectValid   = 1'b0;
        redirectAddress = '0;
        imemReady       = 1'b0;
        imemData        = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_imem_read", 32'(imemRead), 32'd0);
        check_eq("rst_imem_addr", imemAddress, RV);
        check_eq("rst_valid", 32'(instructionValid), 32'd0);
        check_eq("rst_data", instructionData, NOP);
        check_eq("rst_pc", pcAddress, 32'd0);
        check_eq("rst_next_pc", nextPCAddress, 32'd0);
        rst = 1'b1;

        // Sequential fetch, then a stall lands on the 0x8 completion
        mem_lat = 1;
        wait_req(3, "seq_three_requests");
        stall = 1'b1;
        chk_req(0, 32'h0, "seq_req0");
        chk_req(1, 32'h4, "seq_req4");
        chk_req(2, 32'h8, "seq_req8");
        repeat (5) step();
        check_eq("hold_imem_read", 32'(imemRead), 32'd0);
        check_eq("hold_valid_5cyc", 32'(instructionValid), 32'd1);
        check_eq("hold_pc_5cyc", pcAddress, 32'h8);
        check_eq("hold_data_5cyc", instructionData, mem_word(32'h8));
        stall   = 1'b0;
        mem_lat = 3;
        wait_req(4, "after_hold_request");
        chk_req(3, 32'hC, "after_hold_req_c");
        chk_dlv(0, 32'h0, 32'h4, "seq_dlv0");
        chk_dlv(1, 32'h4, 32'h8, "seq_dlv4");
        chk_dlv(2, 32'h8, 32'hC, "seq_dlv8");

        // Redirect while the 0xC request is still pending
        redirectAddress = 32'h100;
        redirectValid   = 1'b1;
        step();
        redirectValid   = 1'b0;
        ndel = dlv_pc_q.size();
        mem_lat = 1;
        wait_req(5, "redirect_pending_request");
        chk_req(4, 32'h100, "redirect_pending_req");
        wait_dlv(ndel + 1, "redirect_pending_delivery");
        chk_dlv(ndel, 32'h100, 32'h104, "redirect_pending_dlv");

        // Redirect coincident with imemReady
        mem_lat = 2;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!(imemRead && imemReady) && cyc < Budget);
        check_eq("found_ready_cycle", 32'(imemRead && imemReady), 32'd1);
        redirectAddress = 32'h203;
        redirectValid   = 1'b1;
        step();
        redirectValid   = 1'b0;
        nreq = req_q.size();
        ndel = dlv_pc_q.size();
        wait_req(nreq + 1, "redirect_at_ready_request");
        chk_req(nreq, 32'h200, "redirect_at_ready_req");
        check_eq("redirect_at_ready_dropped", 32'(dlv_pc_q.size()), 32'(ndel));

        // Reset in the middle of a long request; stray readies are ignored
        mem_lat = 6;
        nreq = req_q.size();
        wait_req(nreq + 1, "pre_reset_request");
        step();
        rst = 1'b0;
        #1;
        check_eq("midreq_rst_read", 32'(imemRead), 32'd0);
        check_eq("midreq_rst_addr", imemAddress, RV);
        check_eq("midreq_rst_valid", 32'(instructionValid), 32'd0);
        mem_force = 1'b1;
        imemReady = 1'b1;
        imemData  = 32'hDEAD_BEEF;
        step();
        step();
        rst = 1'b1;
        mem_force = 1'b0;
        mem_lat   = 1;
        nreq = req_q.size();
        ndel = dlv_pc_q.size();
        wait_req(nreq + 1, "post_reset_request");
        chk_req(nreq, RV, "post_reset_req_addr");
        wait_dlv(ndel + 1, "post_reset_delivery");
        chk_dlv(ndel, RV, RV + 32'd4, "post_reset_dlv");

        // PC wrap at the top of the address space
        mem_lat = 0;
        redirectAddress = 32'hFFFF_FFFF;
        redirectValid   = 1'b1;
        step();
        redirectValid   = 1'b0;
        nreq = req_q.size();
        ndel = dlv_pc_q.size();
        wait_req(nreq + 1, "wrap_request");
        chk_req(nreq, 32'hFFFF_FFFC, "wrap_req_top");
        wait_dlv(ndel + 1, "wrap_delivery");
        chk_dlv(ndel, 32'hFFFF_FFFC, 32'h0, "wrap_dlv");
        wait_req(nreq + 2, "wrap_next_request");
        chk_req(nreq + 1, 32'h0, "wrap_req_zero");

        // Randomized traffic
        mem_lat = -1;
        spur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            stall         = ($urandom_range(0, 2) == 0);
            redirectValid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) redirectAddress = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else redirectAddress = $urandom;
        end
        stall         = 1'b0;
        redirectValid = 1'b0;
        ndel = dlv_pc_q.size();
        repeat (20) step();
        check_eq("drain_progress", 32'(dlv_pc_q.size() > ndel), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
